// File: rtl/fir_decim_sequencer_if.sv
// fir_decim_sequencer_if: handshake bundle between the FIR sequencer and its surroundings.
//   i_din/i_in_empty/o_in_rd_en       : upstream FWFT sample FIFO
//   o_coeff_addr/i_coeff_data         : combinational coefficient ROM
//   o_dout/i_out_full/o_out_wr_en     : downstream result FIFO
//   o_busy                            : sequencer is computing or holding a result
//   modport slave  : the sequencer side
//   modport master : the environment side (FIFOs, ROM, testbench)
interface fir_decim_sequencer_if #(
    parameter int TAPS       = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int AW = $clog2(TAPS);
    logic signed [DATA_WIDTH-1:0] i_din;
    logic                         i_in_empty;
    logic                         o_in_rd_en;
    logic [AW-1:0]                o_coeff_addr;
    logic signed [DATA_WIDTH-1:0] i_coeff_data;
    logic signed [DATA_WIDTH-1:0] o_dout;
    logic                         i_out_full;
    logic                         o_out_wr_en;
    logic                         o_busy;
    modport slave (
        input  i_din, i_in_empty, i_coeff_data, i_out_full,
        output o_in_rd_en, o_coeff_addr, o_dout, o_out_wr_en, o_busy
    );
    modport master (
        output i_din, i_in_empty, i_coeff_data, i_out_full,
        input  o_in_rd_en, o_coeff_addr, o_dout, o_out_wr_en, o_busy
    );
endinterface

// File: rtl/fir_decim_sequencer.sv
// fir_decim_sequencer: decimating FIR stage on one shared multiplier, one tap per clock.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fir_decim_sequencer_if.slave (upstream FIFO, coefficient ROM, downstream FIFO, busy)
//   Optional macro FIR_SEQ_SATURATE_EN: double-width accumulator with output clamping;
//   otherwise the accumulator is DATA_WIDTH wide and wraps.
module fir_decim_sequencer #(
    parameter int TAPS       = 32,
    parameter int DECIM      = 8,
    parameter int DATA_WIDTH = 32,
    parameter int BITS       = 10
) (
    input logic                  clk,
    input logic                  rst_n,
    fir_decim_sequencer_if.slave bus
);
    localparam int AW = $clog2(TAPS);
    localparam int LW = DECIM > 1 ? $clog2(DECIM) : 1;
    localparam int PW = 2 * DATA_WIDTH;
`ifdef FIR_SEQ_SATURATE_EN
    localparam int ACC_W = PW;
`else
    localparam int ACC_W = DATA_WIDTH;
`endif
    typedef enum logic [1:0] {S_LOAD, S_MAC, S_OUT} state_t;
    state_t                       r_state, w_next;
    logic signed [DATA_WIDTH-1:0] r_buf [TAPS];
    logic [AW-1:0]                r_wp, r_k, w_rd_idx;
    logic [LW-1:0]                r_lc;
    logic signed [ACC_W-1:0]      r_acc;
    logic signed [PW-1:0]         w_prod, w_p;
    logic                         w_pop, w_push, w_last_load, w_last_tap;

    assign w_pop       = r_state == S_LOAD && !bus.i_in_empty;
    assign w_push      = r_state == S_OUT && !bus.i_out_full;
    assign w_last_load = r_lc == LW'(DECIM - 1);
    assign w_last_tap  = r_k == AW'(TAPS - 1);
    // Newest sample pairs with coeff[0]; TAPS is a power of two so the index wraps for free.
    assign w_rd_idx    = r_wp - AW'(1) - r_k;
    assign w_prod      = PW'(bus.i_coeff_data) * PW'(r_buf[w_rd_idx]);
    assign w_p         = w_prod >>> BITS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_LOAD;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:  w_next = (w_pop && w_last_load) ? S_MAC : S_LOAD;
            S_MAC:   w_next = w_last_tap ? S_OUT : S_MAC;
            S_OUT:   w_next = w_push ? S_LOAD : S_OUT;
            default: w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_lc  <= '0;
            r_k   <= '0;
            r_acc <= '0;
            for (int i = 0; i < TAPS; i++) r_buf[i] <= '0;
        end else begin
            if (w_pop) begin
                r_buf[r_wp] <= bus.i_din;
                r_wp        <= r_wp + AW'(1);
                r_lc        <= w_last_load ? '0 : r_lc + LW'(1);
                if (w_last_load) begin
                    r_acc <= '0;
                    r_k   <= '0;
                end
            end
            if (r_state == S_MAC) begin
                r_acc <= r_acc + ACC_W'(w_p);
                r_k   <= r_k + AW'(1);
            end
        end
    end

    always_comb begin
        bus.o_in_rd_en   = w_pop;
        bus.o_out_wr_en  = w_push;
        bus.o_busy       = r_state != S_LOAD;
        bus.o_coeff_addr = r_state == S_MAC ? r_k : '0;
    end

`ifdef FIR_SEQ_SATURATE_EN
    logic w_fits;
    // The result fits when every bit above the output sign bit matches it.
    assign w_fits     = (&r_acc[ACC_W-1:DATA_WIDTH-1]) | ~(|r_acc[ACC_W-1:DATA_WIDTH-1]);
    assign bus.o_dout = w_fits ? r_acc[DATA_WIDTH-1:0]
                               : {r_acc[ACC_W-1], {(DATA_WIDTH-1){~r_acc[ACC_W-1]}}};
`else
    assign bus.o_dout = r_acc;
`endif
endmodule

// File: tb/tb_fir_decim_sequencer.sv
// tb_fir_decim_sequencer: scoreboard bench for fir_decim_sequencer (TAPS=8, DECIM=4, BITS=2).
module tb_fir_decim_sequencer;
    localparam int TAPS = 8, DECIM = 4, DW = 32, BITS = 2;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_decim_sequencer_if #(.TAPS(TAPS), .DATA_WIDTH(DW)) bus ();
    fir_decim_sequencer #(.TAPS(TAPS), .DECIM(DECIM), .DATA_WIDTH(DW), .BITS(BITS)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    logic signed [DW-1:0] rom [TAPS];
    assign bus.i_coeff_data = rom[bus.o_coeff_addr];

    int tests = 0, fails = 0, cyc = 0, pushes = 0, grp = 0;
    int last_pop_cyc = 0, last_push_cyc = 0;
    logic signed [DW-1:0] hist [$];
    logic signed [DW-1:0] exp_q [$];
    logic signed [DW-1:0] got_q [$];
    logic signed [DW-1:0] e;

    always @(posedge clk) cyc++;

    function automatic logic signed [DW-1:0] ref_out();
        longint acc, c, s;
        acc = 0;
        for (int k = 0; k < TAPS; k++) begin
            c = rom[k];
            s = 0;
            if (k < hist.size()) s = hist[k];
            acc += (c * s) >>> BITS;
        end
`ifdef FIR_SEQ_SATURATE_EN
        if (acc > MAXV) acc = MAXV;
        if (acc < MINV) acc = MINV;
`endif
        return acc[DW-1:0];
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_in_rd_en) begin
                hist.push_front(bus.i_din);
                if (hist.size() > TAPS) void'(hist.pop_back());
                last_pop_cyc = cyc;
                grp++;
                if (grp == DECIM) begin
                    grp = 0;
                    exp_q.push_back(ref_out());
                end
            end
            if (bus.o_out_wr_en) begin
                pushes++;
                last_push_cyc = cyc;
                got_q.push_back(bus.o_dout);
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL scoreboard_unexpected_push: dout=%h, no result expected", bus.o_dout);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.o_dout !== e) begin
                        fails++;
                        $display("FAIL scoreboard_dout: got %h expected %h", bus.o_dout, e);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic feed(input logic signed [DW-1:0] v);
        int n = 0;
        @(posedge clk); #1;
        bus.i_din = v;
        bus.i_in_empty = 1'b0;
        @(negedge clk);
        while (!bus.o_in_rd_en && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL feed_timeout: in_rd_en stayed 0 for %0d cycles, expected 1", n);
        end
        @(posedge clk); #1;
        bus.i_in_empty = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.o_busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 500) begin
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, busy=%b, expected 0 and 0", exp_q.size(), bus.o_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_idle_zero(input string tag);
        tests++;
        if ({bus.o_in_rd_en, bus.o_out_wr_en, bus.o_busy} !== 3'b000 || bus.o_dout !== '0 || bus.o_coeff_addr !== '0) begin
            fails++;
            $display("FAIL %s: rd_en=%b wr_en=%b busy=%b dout=%h addr=%0d, expected all 0", tag,
                     bus.o_in_rd_en, bus.o_out_wr_en, bus.o_busy, bus.o_dout, bus.o_coeff_addr);
        end
    endtask

    task automatic run_impulse(input string tag);
        int p0;
        for (int k = 0; k < TAPS; k++) rom[k] = (k + 1) << BITS;
        got_q.delete();
        p0 = pushes;
        feed(1);
        for (int i = 0; i < 7; i++) feed(0);
        drain();
        tests++;
        if (pushes - p0 !== 2 || got_q.size() != 2) begin
            fails++;
            $display("FAIL %s_count: got %0d pushes, expected 2", tag, pushes - p0);
        end else begin
            tests++;
            if (got_q[0] !== 32'sd4 || got_q[1] !== 32'sd8) begin
                fails++;
                $display("FAIL %s_values: got %0d,%0d expected 4,8", tag, got_q[0], got_q[1]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_in_empty = 1'b1;
        bus.i_out_full = 1'b0;
        bus.i_din = '0;
        for (int k = 0; k < TAPS; k++) rom[k] = '0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset_outputs");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("after_reset_idle");
    endtask

    task automatic test_impulse();
        run_impulse("impulse");
    endtask

    task automatic test_decimation();
        int p0;
        for (int k = 0; k < TAPS; k++) rom[k] = 1 << BITS;
        got_q.delete();
        p0 = pushes;
        for (int i = 0; i < 2 * DECIM; i++) feed(5);
        drain();
        tests++;
        if (pushes - p0 !== 2 || got_q.size() != 2) begin
            fails++;
            $display("FAIL decim_count: got %0d pushes, expected 2", pushes - p0);
        end else begin
            tests++;
            if (got_q[0] !== 32'sd20 || got_q[1] !== 32'sd40) begin
                fails++;
                $display("FAIL decim_values: got %0d,%0d expected 20,40", got_q[0], got_q[1]);
            end
        end
        tests++;
        if (last_push_cyc - last_pop_cyc !== TAPS + 1) begin
            fails++;
            $display("FAIL decim_latency: got %0d cycles, expected %0d", last_push_cyc - last_pop_cyc, TAPS + 1);
        end
    endtask

    task automatic test_backpressure();
        int p0;
        logic signed [DW-1:0] d;
        logic bad_d, bad_rd, bad_wr;
        bad_d = 1'b0;
        bad_rd = 1'b0;
        bad_wr = 1'b0;
        @(posedge clk); #1;
        bus.i_out_full = 1'b1;
        p0 = pushes;
        for (int i = 0; i < DECIM; i++) feed(7);
        repeat (TAPS + 3) @(negedge clk);
        d = bus.o_dout;
        tests++;
        if (d !== 32'sd48) begin
            fails++;
            $display("FAIL bp_held_value: got %0d expected 48", d);
        end
        @(posedge clk); #1;
        bus.i_din = 99;
        bus.i_in_empty = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.o_dout !== d) bad_d = 1'b1;
            if (bus.o_in_rd_en !== 1'b0) bad_rd = 1'b1;
            if (bus.o_out_wr_en !== 1'b0) bad_wr = 1'b1;
        end
        tests += 3;
        if (bad_d) begin fails++; $display("FAIL bp_dout_stable: dout=%h changed, expected %h", bus.o_dout, d); end
        if (bad_rd) begin fails++; $display("FAIL bp_no_pop: in_rd_en=1 seen, expected 0"); end
        if (bad_wr) begin fails++; $display("FAIL bp_no_push: out_wr_en=1 seen, expected 0"); end
        @(posedge clk); #1;
        bus.i_in_empty = 1'b1;
        bus.i_out_full = 1'b0;
        drain();
        tests++;
        if (pushes - p0 !== 1) begin
            fails++;
            $display("FAIL bp_push_count: got %0d pushes, expected 1", pushes - p0);
        end
    endtask

    task automatic test_starvation();
        int p0;
        logic bad;
        bad = 1'b0;
        p0 = pushes;
        feed(2);
        feed(3);
        feed(4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.o_busy !== 1'b0 || bus.o_out_wr_en !== 1'b0 || bus.o_in_rd_en !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad || pushes != p0) begin
            fails++;
            $display("FAIL starve_stall: activity during stall (pushes %0d), expected none", pushes - p0);
        end
        feed(5);
        drain();
        tests++;
        if (pushes - p0 !== 1) begin
            fails++;
            $display("FAIL starve_push_count: got %0d pushes, expected 1", pushes - p0);
        end
    endtask

    task automatic test_overflow();
        logic signed [DW-1:0] want;
`ifdef FIR_SEQ_SATURATE_EN
        want = 32'sh7FFFFFFF;
`else
        want = 32'sh00000000;
`endif
        for (int k = 0; k < TAPS; k++) rom[k] = 32'sh40000000;
        got_q.delete();
        for (int i = 0; i < 2 * DECIM; i++) feed(4);
        drain();
        tests++;
        if (got_q.size() != 2 || got_q[1] !== want) begin
            fails++;
            $display("FAIL overflow_dout: got %0d results, last %h, expected %h", got_q.size(),
                     got_q.size() > 0 ? got_q[got_q.size()-1] : 32'h0, want);
        end
    endtask

    task automatic test_reset_mid_mac();
        int n = 0, p0;
        for (int k = 0; k < TAPS; k++) rom[k] = (k + 1) << BITS;
        p0 = pushes;
        for (int i = 0; i < DECIM; i++) feed(9);
        @(negedge clk);
        while (!(bus.o_busy && bus.o_coeff_addr == 3'd5) && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 100) begin
            fails++;
            $display("FAIL midreset_reach_k5: coeff_addr=%0d busy=%b, expected 5 and 1", bus.o_coeff_addr, bus.o_busy);
        end
        rst_n = 1'b0;
        hist.delete();
        exp_q.delete();
        grp = 0;
        repeat (TAPS + 4) @(negedge clk);
        check_idle_zero("midreset_outputs");
        tests++;
        if (pushes !== p0) begin
            fails++;
            $display("FAIL midreset_no_push: got %0d pushes, expected 0", pushes - p0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_impulse("impulse_after_reset");
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_decimation();
        test_backpressure();
        test_starvation();
        test_overflow();
        test_reset_mid_mac();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_leftover: %0d results never pushed, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
